// File: rtl/maxpool_stream_if.sv
// Stream interface for maxpool_stream.
// Groups the input and output valid/ready channels.
//   slave  : the pooling block. It consumes in_*, produces in_ready and out_*, and consumes out_ready.
//   master : the surrounding environment, which has the opposite directions.
// Handshake: a channel transfers on a rising edge where valid && ready are both high.
// Once valid is raised, the producer holds data (and out_last) stable until that transfer happens.
interface maxpool_stream_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming non-overlapping POOL x POOL max-pool over FP16 data.
//
// Input order is raster order with channels interleaved (channel fastest).
// Output is the pooled map in the same order: (oy, ox, c).
// Partial maxima live in one row of per-(ox, c) accumulators.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous frame abort. Zeroes the counters and drops the held output.
//            It wins over a same-cycle input transfer.
//   stream : maxpool_stream_if.slave, carrying in_data/in_valid/in_ready and
//            out_data/out_valid/out_ready/out_last
module maxpool_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_W      = 20,
   parameter int IMG_H      = 20,
   parameter int CH         = 1,
   parameter int POOL       = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   maxpool_stream_if.slave stream
);

   localparam int OUT_W = IMG_W / POOL;
   localparam int OUT_H = IMG_H / POOL;
   localparam int ACC_N = OUT_W * CH;
   localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int PW    = $clog2(POOL);
   localparam int AW    = $clog2(IMG_W * CH + 1);
   localparam int IW    = (ACC_N > 1) ? $clog2(ACC_N) : 1;

   // Maps sign-magnitude floats onto an unsigned scale that preserves ordering.
   function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] msb;
      msb = '0;
      msb[DATA_WIDTH-1] = 1'b1;
      return v[DATA_WIDTH-1] ? ~v : (v | msb);
   endfunction

   // Returns the held value on equal keys.
   function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] held,
                                                   input logic [DATA_WIDTH-1:0] v);
      return (order_key(v) > order_key(held)) ? v : held;
   endfunction

   // Position counters. wx/wy are positions inside the window, ox/oy are window indices.
   // base tracks ox*CH, so the accumulator index needs no multiplier.
   logic [CW-1:0] c_q, c_d;
   logic [XW-1:0] x_q, x_d, ox_q, ox_d;
   logic [YW-1:0] y_q, y_d, oy_q, oy_d;
   logic [PW-1:0] wx_q, wx_d, wy_q, wy_d;
   logic [AW-1:0] base_q, base_d;

   logic [DATA_WIDTH-1:0] acc_q [ACC_N];
   logic [DATA_WIDTH-1:0] acc_d [ACC_N];

   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;

   logic                  in_ready;
   logic                  accept;
   logic                  in_window;
   logic                  first_elem;
   logic                  complete;
   logic                  is_last;
   logic [AW-1:0]         acc_idx;
   logic [IW-1:0]         rd_idx;
   logic [DATA_WIDTH-1:0] held;
   logic [DATA_WIDTH-1:0] pooled;

   // The output register can take a new value whenever the current one retires in the same edge.
   assign in_ready  = rst_n & (~out_valid_q | stream.out_ready);
   assign accept    = stream.in_valid & in_ready;

   // Trailing columns and rows, beyond the last full window, are accepted and dropped.
   assign in_window  = (ox_q < XW'(OUT_W)) && (oy_q < YW'(OUT_H));
   assign first_elem = (wx_q == '0) && (wy_q == '0);
   assign complete   = in_window && (wx_q == PW'(POOL - 1)) && (wy_q == PW'(POOL - 1));
   assign is_last    = (ox_q == XW'(OUT_W - 1)) && (oy_q == YW'(OUT_H - 1))
                       && (c_q == CW'(CH - 1));

   assign acc_idx = base_q + AW'(c_q);
   assign rd_idx  = in_window ? IW'(acc_idx) : '0;
   assign held    = acc_q[rd_idx];
   assign pooled  = first_elem ? stream.in_data : fp_max(held, stream.in_data);

   always_comb begin
      c_d         = c_q;
      x_d         = x_q;
      y_d         = y_q;
      ox_d        = ox_q;
      oy_d        = oy_q;
      wx_d        = wx_q;
      wy_d        = wy_q;
      base_d      = base_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      if (clear) begin
         c_d         = '0;
         x_d         = '0;
         y_d         = '0;
         ox_d        = '0;
         oy_d        = '0;
         wx_d        = '0;
         wy_d        = '0;
         base_d      = '0;
         out_data_d  = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         if (stream.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
         if (accept) begin
            if (in_window) begin
               acc_d[rd_idx] = pooled;
            end
            if (complete) begin
               out_data_d  = pooled;
               out_valid_d = 1'b1;
               out_last_d  = is_last;
            end
            if (c_q == CW'(CH - 1)) begin
               c_d = '0;
               if (x_q == XW'(IMG_W - 1)) begin
                  x_d    = '0;
                  wx_d   = '0;
                  ox_d   = '0;
                  base_d = '0;
                  if (y_q == YW'(IMG_H - 1)) begin
                     y_d  = '0;
                     wy_d = '0;
                     oy_d = '0;
                  end else begin
                     y_d = y_q + YW'(1);
                     if (wy_q == PW'(POOL - 1)) begin
                        wy_d = '0;
                        oy_d = oy_q + YW'(1);
                     end else begin
                        wy_d = wy_q + PW'(1);
                     end
                  end
               end else begin
                  x_d = x_q + XW'(1);
                  if (wx_q == PW'(POOL - 1)) begin
                     wx_d   = '0;
                     ox_d   = ox_q + XW'(1);
                     base_d = base_q + AW'(CH);
                  end else begin
                     wx_d = wx_q + PW'(1);
                  end
               end
            end else begin
               c_d = c_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         ox_q        <= '0;
         oy_q        <= '0;
         wx_q        <= '0;
         wy_q        <= '0;
         base_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < ACC_N; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         c_q         <= c_d;
         x_q         <= x_d;
         y_q         <= y_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         wx_q        <= wx_d;
         wy_q        <= wy_d;
         base_q      <= base_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         acc_q       <= acc_d;
      end
   end

   assign stream.in_ready  = in_ready;
   assign stream.out_data  = out_data_q;
   assign stream.out_valid = out_valid_q;
   assign stream.out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream, using two instances:
//   dut_a : 5x5, CH=1, POOL=5. One output per frame.
//   dut_b : 12x11, CH=2, POOL=5. Has trailing columns and rows; 8 outputs per frame.
// Expected outputs are queued as {last, data} and compared when the DUT hands them over.
module tb_maxpool_stream;

   localparam int W = 17;

   logic clk;
   logic rst_n;
   logic clear_a;
   logic clear_b;

   maxpool_stream_if #(.DATA_WIDTH(16)) ifa ();
   maxpool_stream_if #(.DATA_WIDTH(16)) ifb ();

   maxpool_stream #(.DATA_WIDTH(16), .IMG_W(5), .IMG_H(5), .CH(1), .POOL(5)) dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_a),
      .stream (ifa.slave)
   );

   maxpool_stream #(.DATA_WIDTH(16), .IMG_W(12), .IMG_H(11), .CH(2), .POOL(5)) dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_b),
      .stream (ifb.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_qa[$];
   logic [W-1:0] exp_qb[$];

   // out_ready mode: 0 always ready, 1 random 50%, 2 never ready
   int mode_a;
   int mode_b;
   int out_cnt_b;

   logic         stall_a, stall_b;
   logic [W-1:0] prev_a, prev_b;

   logic [15:0] head9  [9];
   logic [15:0] neg3   [3];
   logic [15:0] img_b  [11][12][2];
   logic [15:0] rnd_a  [25];
   logic [15:0] m;
   time         t0, t1;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sign-magnitude maximum. Positive beats negative; among negatives the smaller magnitude wins.
   // On a tie the held value stays.
   function automatic logic [15:0] ref_max(input logic [15:0] held, input logic [15:0] v);
      if (held[15] != v[15]) return held[15] ? v : held;
      if (!held[15]) return (v[14:0] > held[14:0]) ? v : held;
      return (v[14:0] < held[14:0]) ? v : held;
   endfunction

   // ---------------- drivers ----------------
   task automatic push(input bit sel_b, input logic [15:0] d);
      int n;
      n = 0;
      if (sel_b) begin
         ifb.in_data  = d;
         ifb.in_valid = 1'b1;
      end else begin
         ifa.in_data  = d;
         ifa.in_valid = 1'b1;
      end
      @(negedge clk);
      while (!(sel_b ? ifb.in_ready : ifa.in_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(sel_b ? "accept_wait_b" : "accept_wait_a", 32'(n < 200), 32'd1);
      @(posedge clk);
      #1;
      if (sel_b) ifb.in_valid = 1'b0;
      else       ifa.in_valid = 1'b0;
   endtask

   task automatic drain(input bit sel_b);
      int n;
      n = 0;
      while ((sel_b ? exp_qb.size() : exp_qa.size()) != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(sel_b ? "drain_b" : "drain_a", 32'(sel_b ? exp_qb.size() : exp_qa.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      ifa.out_ready = (mode_a == 0) ? 1'b1 : (mode_a == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      ifb.out_ready = (mode_b == 0) ? 1'b1 : (mode_b == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst_n) begin
         chk("in_ready_a", 32'(ifa.in_ready), 32'(!(ifa.out_valid && !ifa.out_ready)));
         if (stall_a)
            chk("hold_a", 32'({ifa.out_valid, ifa.out_last, ifa.out_data}), 32'({1'b1, prev_a}));
         if (ifa.out_valid && ifa.out_ready) begin
            chk("sb_a_pending", 32'(exp_qa.size() != 0), 32'd1);
            if (exp_qa.size() != 0) begin
               e = exp_qa.pop_front();
               chk("out_a", 32'({ifa.out_last, ifa.out_data}), 32'(e));
            end
         end
         stall_a = ifa.out_valid && !ifa.out_ready;
         prev_a  = {ifa.out_last, ifa.out_data};
      end else begin
         stall_a = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst_n) begin
         chk("in_ready_b", 32'(ifb.in_ready), 32'(!(ifb.out_valid && !ifb.out_ready)));
         if (stall_b)
            chk("hold_b", 32'({ifb.out_valid, ifb.out_last, ifb.out_data}), 32'({1'b1, prev_b}));
         if (ifb.out_valid && ifb.out_ready) begin
            out_cnt_b++;
            chk("sb_b_pending", 32'(exp_qb.size() != 0), 32'd1);
            if (exp_qb.size() != 0) begin
               e = exp_qb.pop_front();
               chk("out_b", 32'({ifb.out_last, ifb.out_data}), 32'(e));
            end
         end
         stall_b = ifb.out_valid && !ifb.out_ready;
         prev_b  = {ifb.out_last, ifb.out_data};
      end else begin
         stall_b = 1'b0;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n         = 1'b0;
      clear_a       = 1'b0;
      clear_b       = 1'b0;
      ifa.in_valid  = 1'b0;
      ifa.in_data   = '0;
      ifb.in_valid  = 1'b0;
      ifb.in_data   = '0;
      ifa.out_ready = 1'b1;
      ifb.out_ready = 1'b1;
      mode_a        = 0;
      mode_b        = 0;
      out_cnt_b     = 0;
      stall_a       = 1'b0;
      stall_b       = 1'b0;
      prev_a        = '0;
      prev_b        = '0;
      head9 = '{16'hBC00, 16'hC000, 16'hC200, 16'hC400, 16'hC000,
                16'hC200, 16'hC400, 16'hC500, 16'h4400};
      neg3  = '{16'hBC00, 16'hC000, 16'hC500};

      // Reset state
      #12;
      chk("rst_out_a", 32'({ifa.out_valid, ifa.out_last, ifa.out_data}), 32'd0);
      chk("rst_in_ready_a", 32'(ifa.in_ready), 32'd0);
      chk("rst_out_b", 32'({ifb.out_valid, ifb.out_last, ifb.out_data}), 32'd0);
      chk("rst_in_ready_b", 32'(ifb.in_ready), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready_a", 32'(ifa.in_ready), 32'd1);

      // Test 1: single 4200 among 4000, with latency check
      exp_qa.push_back({1'b1, 16'h4200});
      for (int i = 0; i < 25; i++) begin
         if (i == 24) chk("t1_pre_valid", 32'(ifa.out_valid), 32'd0);
         push(1'b0, (i == 20) ? 16'h4200 : 16'h4000);
      end
      chk("t1_latency", 32'({ifa.out_valid, ifa.out_last, ifa.out_data}), 32'({2'b11, 16'h4200}));
      drain(1'b0);

      // Test 2: three back-to-back frames covering ordering corner cases
      exp_qa.push_back({1'b1, 16'h4500});
      exp_qa.push_back({1'b1, 16'hBC00});
      exp_qa.push_back({1'b1, 16'h0000});
      t0 = $time;
      for (int i = 0; i < 25; i++)
         push(1'b0, (i < 9) ? head9[i] : (i < 24) ? 16'h4200 : 16'h4500);
      for (int i = 0; i < 25; i++)
         push(1'b0, neg3[i % 3]);
      for (int i = 0; i < 25; i++)
         push(1'b0, (i % 2 == 0) ? 16'h8000 : 16'h0000);
      t1 = $time;
      chk("t2_throughput", 32'((t1 - t0) / 10), 32'd75);
      drain(1'b0);

      // Test 3: 12x11x2 random data, with random back-pressure on dut_b
      mode_b = 1;
      for (int y = 0; y < 11; y++)
         for (int x = 0; x < 12; x++)
            for (int c = 0; c < 2; c++)
               img_b[y][x][c] = 16'($urandom_range(0, 65535));
      for (int oy = 0; oy < 2; oy++)
         for (int ox = 0; ox < 2; ox++)
            for (int c = 0; c < 2; c++) begin
               m = img_b[oy * 5][ox * 5][c];
               for (int wy = 0; wy < 5; wy++)
                  for (int wx = 0; wx < 5; wx++)
                     m = ref_max(m, img_b[oy * 5 + wy][ox * 5 + wx][c]);
               exp_qb.push_back({(oy == 1 && ox == 1 && c == 1), m});
            end
      for (int y = 0; y < 11; y++)
         for (int x = 0; x < 12; x++)
            for (int c = 0; c < 2; c++)
               push(1'b1, img_b[y][x][c]);
      drain(1'b1);
      repeat (10) @(negedge clk);
      chk("count_b", 32'(out_cnt_b), 32'd8);
      mode_b = 0;

      // Test 4: clear after 13 elements. The transfer in the clear cycle is dropped.
      for (int i = 0; i < 13; i++)
         push(1'b0, 16'h7000);
      clear_a      = 1'b1;
      ifa.in_data  = 16'h7BFF;
      ifa.in_valid = 1'b1;
      @(posedge clk);
      #1;
      clear_a      = 1'b0;
      ifa.in_valid = 1'b0;
      chk("t4_clear_valid", 32'(ifa.out_valid), 32'd0);
      exp_qa.push_back({1'b1, 16'h3C00});
      for (int i = 0; i < 25; i++)
         push(1'b0, 16'h3C00);
      drain(1'b0);

      // Test 5: asynchronous reset while an output is held
      mode_a = 2;
      @(posedge clk);
      #2;
      for (int i = 0; i < 25; i++)
         push(1'b0, 16'h4400);
      repeat (3) @(negedge clk);
      chk("t5_held", 32'({ifa.out_valid, ifa.out_last, ifa.out_data}), 32'({2'b11, 16'h4400}));
      #3 rst_n = 1'b0;
      #1;
      chk("t5_rst_out", 32'({ifa.out_valid, ifa.out_last, ifa.out_data}), 32'd0);
      chk("t5_rst_in_ready", 32'(ifa.in_ready), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      mode_a = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 25; i++)
         rnd_a[i] = 16'($urandom_range(0, 65535));
      m = rnd_a[0];
      for (int i = 1; i < 25; i++)
         m = ref_max(m, rnd_a[i]);
      exp_qa.push_back({1'b1, m});
      for (int i = 0; i < 25; i++)
         push(1'b0, rnd_a[i]);
      drain(1'b0);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
